// File: rtl/line_buffer_7x7_pkg.sv
// ============================================================================
// Module      : line_buffer_7x7_pkg
// Description : Shared image-pipeline constants for the 7x7 window stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package line_buffer_7x7_pkg;
   localparam int PIX_W       = 8;
   localparam int KERNEL      = 7;
   localparam int c_NUM_LINES = KERNEL - 1;
endpackage

`default_nettype wire

// File: rtl/line_buffer_7x7_line_ram.sv
// ============================================================================
// Module      : line_ram
// Description : Simple dual-port line memory, read-before-write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_ram #(
   parameter int DEPTH  = 640,
   parameter int WIDTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   // Storage is deliberately left unreset; only the read register clears.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (rd_en) begin
         r_rd_data <= r_mem[rd_addr];
      end
   end

   assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/line_buffer_7x7.sv
// ============================================================================
// Module      : line_buffer_7x7
// Description : Six-line cascade producing 7-pixel vertical columns from raster input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer_7x7
   import line_buffer_7x7_pkg::*;
#(
   parameter int COLS = 640,
   parameter int ROWS = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] data_i,
   input  logic             valid_i,
   output logic [PIX_W-1:0] d0_o,
   output logic [PIX_W-1:0] d1_o,
   output logic [PIX_W-1:0] d2_o,
   output logic [PIX_W-1:0] d3_o,
   output logic [PIX_W-1:0] d4_o,
   output logic [PIX_W-1:0] d5_o,
   output logic [PIX_W-1:0] d6_o,
   output logic             valid_o,
   output logic             done_o
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam logic [COL_W-1:0] c_COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] c_ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0] c_ROW_FIRST = ROW_W'(KERNEL - 1);

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             r_wr_pend;
   logic [COL_W-1:0] r_wr_addr;
   logic [PIX_W-1:0] r_d6;
   logic             r_valid;
   logic             r_done;
   logic             w_col_wrap;
   logic             w_frame_end;
   logic [PIX_W-1:0] w_rd [c_NUM_LINES];

   assign w_col_wrap  = (r_col == c_COL_LAST);
   assign w_frame_end = w_col_wrap && (r_row == c_ROW_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (valid_i) begin
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= w_frame_end ? '0 : r_row + ROW_W'(1);
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
         r_d6      <= '0;
         r_wr_pend <= 1'b0;
         r_wr_addr <= '0;
      end else begin
         r_valid   <= valid_i && (r_row >= c_ROW_FIRST);
         r_done    <= valid_i && w_frame_end;
         r_wr_pend <= valid_i;
         if (valid_i) begin
            r_d6      <= data_i;
            r_wr_addr <= r_col;
         end
      end
   end

   // The cascade shift is written one cycle after the read, using the
   // registered read data; the column is not revisited for COLS pixels.
   for (genvar k = 0; k < c_NUM_LINES; k++) begin : g_line
      logic [PIX_W-1:0] w_wr_data;

      if (k == c_NUM_LINES - 1) begin : g_newest
         assign w_wr_data = r_d6;
      end else begin : g_shift
         assign w_wr_data = w_rd[k+1];
      end

      line_ram #(
         .DEPTH  (COLS),
         .WIDTH  (PIX_W),
         .ADDR_W (COL_W)
      ) u_line_ram (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (r_wr_pend),
         .wr_addr (r_wr_addr),
         .wr_data (w_wr_data),
         .rd_en   (valid_i),
         .rd_addr (r_col),
         .rd_data (w_rd[k])
      );
   end

   assign d0_o    = w_rd[0];
   assign d1_o    = w_rd[1];
   assign d2_o    = w_rd[2];
   assign d3_o    = w_rd[3];
   assign d4_o    = w_rd[4];
   assign d5_o    = w_rd[5];
   assign d6_o    = r_d6;
   assign valid_o = r_valid;
   assign done_o  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_line_buffer_7x7.sv
// ============================================================================
// Module      : tb_line_buffer_7x7
// Description : Self-checking bench for line_buffer_7x7 against a frame-array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_buffer_7x7;

   localparam int COLS = 8;
   localparam int ROWS = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_i;
   logic       valid_i;
   logic [7:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o;
   logic       valid_o;
   logic       done_o;
   logic [7:0] dq [7];

   always #5 clk = ~clk;

   assign dq[0] = d0_o;
   assign dq[1] = d1_o;
   assign dq[2] = d2_o;
   assign dq[3] = d3_o;
   assign dq[4] = d4_o;
   assign dq[5] = d5_o;
   assign dq[6] = d6_o;

   line_buffer_7x7 #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data_i),
      .valid_i (valid_i),
      .d0_o    (d0_o),
      .d1_o    (d1_o),
      .d2_o    (d2_o),
      .d3_o    (d3_o),
      .d4_o    (d4_o),
      .d5_o    (d5_o),
      .d6_o    (d6_o),
      .valid_o (valid_o),
      .done_o  (done_o)
   );

   int         n_checks = 0;
   int         n_fail   = 0;

   // Model state: pixels stored by (row, col) of the current frame.
   logic [7:0] img [ROWS][COLS];
   int         pos;
   logic       e_valid, e_done, e_known;
   logic [7:0] e_d [7];

   int         n_vo, n_do;
   logic       seen_first;
   logic [7:0] first_d0, first_d3, first_d6, done_d0, done_d6;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic r);
      int row, col;
      rst     = r;
      valid_i = v;
      data_i  = d;
      if (r) begin
         pos     = 0;
         e_valid = 1'b0;
         e_done  = 1'b0;
         e_known = 1'b1;
         for (int k = 0; k < 7; k++) e_d[k] = 8'h00;
      end else if (v) begin
         row = pos / COLS;
         col = pos % COLS;
         img[row][col] = d;
         e_valid = (row >= 6);
         e_done  = (row == ROWS - 1) && (col == COLS - 1);
         e_known = e_valid;
         e_d[6]  = d;
         if (e_valid) begin
            for (int k = 0; k < 6; k++) e_d[k] = img[row-6+k][col];
         end
         pos = e_done ? 0 : pos + 1;
      end else begin
         e_valid = 1'b0;
         e_done  = 1'b0;
      end
      @(negedge clk);
      check_eq("valid_o", 32'(valid_o), 32'(e_valid));
      check_eq("done_o", 32'(done_o), 32'(e_done));
      check_eq("d6_o", 32'(d6_o), 32'(e_d[6]));
      if (e_known) begin
         for (int k = 0; k < 6; k++) check_eq($sformatf("d%0d_o", k), 32'(dq[k]), 32'(e_d[k]));
      end
      if (valid_o === 1'b1) begin
         n_vo++;
         if (!seen_first) begin
            seen_first = 1'b1;
            first_d0 = d0_o;
            first_d3 = d3_o;
            first_d6 = d6_o;
         end
      end
      if (done_o === 1'b1) begin
         n_do++;
         done_d0 = d0_o;
         done_d6 = d6_o;
      end
   endtask

   // gap: idle cycles after each pixel; rnd_v adds random idles; stop_at < 0 runs the full frame.
   task automatic feed_frame(input int gap, input bit rnd_data, input bit rnd_v, input int stop_at);
      logic [7:0] px;
      n_vo = 0;
      n_do = 0;
      seen_first = 1'b0;
      for (int p = 0; p < ROWS * COLS; p++) begin
         if (p == stop_at) return;
         if (p == 6 * COLS) check_eq("no_valid_rows0_5", 32'(n_vo), 32'd0);
         px = rnd_data ? 8'($urandom) : 8'(((p / COLS) * 16) + (p % COLS));
         step(1'b1, px, 1'b0);
         for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), 1'b0);
         if (rnd_v) begin
            while ($urandom_range(0, 9) < 3) step(1'b0, 8'($urandom), 1'b0);
         end
      end
   endtask

   task automatic check_pattern_frame(input string tag);
      check_eq({tag, "_valid_count"}, 32'(n_vo), 32'(COLS * (ROWS - 6)));
      check_eq({tag, "_done_count"}, 32'(n_do), 32'd1);
      check_eq({tag, "_first_d0"}, 32'(first_d0), 32'h00);
      check_eq({tag, "_first_d3"}, 32'(first_d3), 32'h30);
      check_eq({tag, "_first_d6"}, 32'(first_d6), 32'h60);
      check_eq({tag, "_done_d0"}, 32'(done_d0), 32'h37);
      check_eq({tag, "_done_d6"}, 32'(done_d6), 32'h97);
   endtask

   initial begin
      rst     = 1'b1;
      valid_i = 1'b0;
      data_i  = 8'h00;
      pos     = 0;
      @(negedge clk);
      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h5a, 1'b1);

      // Continuous frame, then a back-to-back second frame.
      feed_frame(0, 1'b0, 1'b0, -1);
      check_pattern_frame("frame1");
      feed_frame(0, 1'b0, 1'b0, -1);
      check_pattern_frame("frame2_b2b");

      // 1-on/2-off gapped input.
      feed_frame(2, 1'b0, 1'b0, -1);
      check_pattern_frame("gapped");

      // Abandon a frame at row 7, column 3.
      feed_frame(0, 1'b0, 1'b0, 7 * COLS + 3);
      step(1'b1, 8'h73, 1'b1);
      check_eq("abort_no_done", 32'(n_do), 32'd0);
      feed_frame(0, 1'b0, 1'b0, -1);
      check_pattern_frame("after_reset");

      // Random data with random gaps.
      for (int f = 0; f < 3; f++) begin
         feed_frame(0, 1'b1, 1'b1, -1);
         check_eq("rand_valid_count", 32'(n_vo), 32'(COLS * (ROWS - 6)));
         check_eq("rand_done_count", 32'(n_do), 32'd1);
      end

      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
